// File: rtl/csr_trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_ctrl_if
// Description : Bundle of signals between the pipeline and the machine-mode
//               CSR / trap controller.
//               master : pipeline side. Drives the CSR write/read requests,
//                        the memory-stage instruction info and the interrupt
//                        request lines.
//               slave  : CSR block side. Returns the read data, the trap code,
//                        mepc and mtvec.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_trap_ctrl_if;
  logic        csr_we_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic [11:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        exc_ecall_i;
  logic        exc_ebreak_i;
  logic        exc_illegal_i;
  logic        exc_ldmis_i;
  logic        exc_stmis_i;
  logic        exc_mret_i;
  logic        timer_irq_i;
  logic        ext_irq_i;
  logic [31:0] excepttype_o;
  logic [31:0] mepc_o;
  logic [31:0] mtvec_o;

  modport master (
    output csr_we_i, csr_waddr_i, csr_wdata_i, csr_raddr_i,
    output mem_valid_i, mem_pc_i,
    output exc_ecall_i, exc_ebreak_i, exc_illegal_i,
    output exc_ldmis_i, exc_stmis_i, exc_mret_i,
    output timer_irq_i, ext_irq_i,
    input  csr_rdata_o, excepttype_o, mepc_o, mtvec_o
  );

  modport slave (
    input  csr_we_i, csr_waddr_i, csr_wdata_i, csr_raddr_i,
    input  mem_valid_i, mem_pc_i,
    input  exc_ecall_i, exc_ebreak_i, exc_illegal_i,
    input  exc_ldmis_i, exc_stmis_i, exc_mret_i,
    input  timer_irq_i, ext_irq_i,
    output csr_rdata_o, excepttype_o, mepc_o, mtvec_o
  );
endinterface
`default_nettype wire

// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_ctrl
// Description : Machine-mode CSR file and trap controller. Holds mstatus,
//               mie, mtvec, mepc, mcause, mip (read-only) and the 64-bit
//               mcycle counter; prioritises memory-stage exceptions and
//               interrupts into a trap code and performs the trap / mret
//               state updates.
// Ports       : clk  - clock, all state changes on its rising edge
//               rst  - asynchronous active-high reset
//               bus  - csr_trap_ctrl_if.slave: CSR write/read port,
//                      memory-stage instruction info, interrupt lines,
//                      trap code, mepc and mtvec outputs
// Revision    : 1.0 - initial release
// ============================================================================
module csr_trap_ctrl #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input wire logic        clk,
  input wire logic        rst,
  csr_trap_ctrl_if.slave  bus
);

  localparam logic [11:0] c_addr_mstatus = 12'h300;
  localparam logic [11:0] c_addr_mie     = 12'h304;
  localparam logic [11:0] c_addr_mtvec   = 12'h305;
  localparam logic [11:0] c_addr_mepc    = 12'h341;
  localparam logic [11:0] c_addr_mcause  = 12'h342;
  localparam logic [11:0] c_addr_mip     = 12'h344;
  localparam logic [11:0] c_addr_mcycle  = 12'hB00;
  localparam logic [11:0] c_addr_mcycleh = 12'hB80;

  localparam logic [31:0] c_exc_none    = 32'd0;
  localparam logic [31:0] c_exc_ecall   = 32'd1;
  localparam logic [31:0] c_exc_ebreak  = 32'd2;
  localparam logic [31:0] c_exc_timer   = 32'd3;
  localparam logic [31:0] c_exc_ext     = 32'd4;
  localparam logic [31:0] c_exc_illegal = 32'd5;
  localparam logic [31:0] c_exc_ldmis   = 32'd6;
  localparam logic [31:0] c_exc_stmis   = 32'd7;
  localparam logic [31:0] c_exc_mret    = 32'hFFFF_FFFF;

  localparam logic [31:0] c_epc_mask    = 32'hFFFF_FFFC;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic        r_mie_mtie;
  logic        r_mie_meie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;      // bits 1:0 are always stored as 0
  logic [31:0] r_mcause;
  logic [63:0] r_mcycle;

  // --------------------------------------------------------------------------
  // Write decode
  // --------------------------------------------------------------------------
  logic w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mepc, w_wr_mcause;
  logic w_wr_mcycle, w_wr_mcycleh;

  assign w_wr_mstatus = bus.csr_we_i && (bus.csr_waddr_i == c_addr_mstatus);
  assign w_wr_mie     = bus.csr_we_i && (bus.csr_waddr_i == c_addr_mie);
  assign w_wr_mtvec   = bus.csr_we_i && (bus.csr_waddr_i == c_addr_mtvec);
  assign w_wr_mepc    = bus.csr_we_i && (bus.csr_waddr_i == c_addr_mepc);
  assign w_wr_mcause  = bus.csr_we_i && (bus.csr_waddr_i == c_addr_mcause);
  assign w_wr_mcycle  = bus.csr_we_i && (bus.csr_waddr_i == c_addr_mcycle);
  assign w_wr_mcycleh = bus.csr_we_i && (bus.csr_waddr_i == c_addr_mcycleh);

  // --------------------------------------------------------------------------
  // Trap prioritisation
  // --------------------------------------------------------------------------
  logic        w_ext_pend;
  logic        w_tmr_pend;
  logic [31:0] w_exc;
  logic        w_trap;
  logic        w_mret;
  logic [31:0] w_cause;

  // Level-sensitive: nothing is remembered while masked.
  assign w_ext_pend = bus.ext_irq_i   && r_mie_meie && r_mstatus_mie;
  assign w_tmr_pend = bus.timer_irq_i && r_mie_mtie && r_mstatus_mie;

  always_comb begin
    w_exc = c_exc_none;
    if (!rst && bus.mem_valid_i) begin
      if      (w_ext_pend)        w_exc = c_exc_ext;
      else if (w_tmr_pend)        w_exc = c_exc_timer;
      else if (bus.exc_illegal_i) w_exc = c_exc_illegal;
      else if (bus.exc_ecall_i)   w_exc = c_exc_ecall;
      else if (bus.exc_ebreak_i)  w_exc = c_exc_ebreak;
      else if (bus.exc_ldmis_i)   w_exc = c_exc_ldmis;
      else if (bus.exc_stmis_i)   w_exc = c_exc_stmis;
      else if (bus.exc_mret_i)    w_exc = c_exc_mret;
    end
  end

  assign w_trap = (w_exc != c_exc_none) && (w_exc != c_exc_mret);
  assign w_mret = (w_exc == c_exc_mret);

  always_comb begin
    w_cause = 32'd0;
    case (w_exc)
      c_exc_ext:     w_cause = 32'h8000_000B;
      c_exc_timer:   w_cause = 32'h8000_0007;
      c_exc_illegal: w_cause = 32'd2;
      c_exc_ecall:   w_cause = 32'd11;
      c_exc_ebreak:  w_cause = 32'd3;
      c_exc_ldmis:   w_cause = 32'd4;
      c_exc_stmis:   w_cause = 32'd6;
      default:       w_cause = 32'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers. Trap and mret updates take precedence over a coincident CSR
  // write to the registers they modify.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
    end else if (w_trap) begin
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (w_mret) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_wr_mstatus) begin
      r_mstatus_mie  <= bus.csr_wdata_i[3];
      r_mstatus_mpie <= bus.csr_wdata_i[7];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mepc   <= 32'd0;
      r_mcause <= 32'd0;
    end else if (w_trap) begin
      r_mepc   <= bus.mem_pc_i & c_epc_mask;
      r_mcause <= w_cause;
    end else begin
      if (w_wr_mepc)   r_mepc   <= bus.csr_wdata_i & c_epc_mask;
      if (w_wr_mcause) r_mcause <= bus.csr_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mie_mtie <= 1'b0;
      r_mie_meie <= 1'b0;
      r_mtvec    <= MTVEC_RESET;
    end else begin
      if (w_wr_mie) begin
        r_mie_mtie <= bus.csr_wdata_i[7];
        r_mie_meie <= bus.csr_wdata_i[11];
      end
      if (w_wr_mtvec) r_mtvec <= bus.csr_wdata_i;
    end
  end

  // A write to either half loads that half and holds the other for the cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcycle <= 64'd0;
    end else if (w_wr_mcycle) begin
      r_mcycle[31:0]  <= bus.csr_wdata_i;
    end else if (w_wr_mcycleh) begin
      r_mcycle[63:32] <= bus.csr_wdata_i;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Read port with write-to-read bypass
  // --------------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = 32'd0;
    if (bus.csr_we_i && (bus.csr_waddr_i == bus.csr_raddr_i)) begin
      w_rdata = bus.csr_wdata_i;
    end else begin
      case (bus.csr_raddr_i)
        c_addr_mstatus: w_rdata = {24'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
        c_addr_mie:     w_rdata = {20'd0, r_mie_meie, 3'd0, r_mie_mtie, 7'd0};
        c_addr_mtvec:   w_rdata = r_mtvec;
        c_addr_mepc:    w_rdata = r_mepc;
        c_addr_mcause:  w_rdata = r_mcause;
        c_addr_mip:     w_rdata = {20'd0, bus.ext_irq_i, 3'd0, bus.timer_irq_i, 7'd0};
        c_addr_mcycle:  w_rdata = r_mcycle[31:0];
        c_addr_mcycleh: w_rdata = r_mcycle[63:32];
        default:        w_rdata = 32'd0;
      endcase
    end
  end

  assign bus.csr_rdata_o  = w_rdata;
  assign bus.excepttype_o = w_exc;
  assign bus.mtvec_o      = w_wr_mtvec ? bus.csr_wdata_i : r_mtvec;
  // Forced to 0 in reset so a pending write cannot leak out as a return address.
  assign bus.mepc_o       = rst        ? 32'd0 :
                            w_wr_mepc  ? (bus.csr_wdata_i & c_epc_mask) : r_mepc;

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_trap_ctrl
// Description : Directed testbench for csr_trap_ctrl. Stimulus pushes the
//               hand-computed expected values for the current cycle into a
//               scoreboard queue; a monitor on the falling edge pops and
//               compares them against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_trap_ctrl;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1000;

  localparam int c_sel_rdata = 0;
  localparam int c_sel_exc   = 1;
  localparam int c_sel_mepc  = 2;
  localparam int c_sel_mtvec = 3;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  csr_trap_ctrl_if bus();

  csr_trap_ctrl #(.MTVEC_RESET(MTVEC_RST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  task automatic exp_push(input int sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.csr_we_i      = 1'b0;
    bus.csr_waddr_i   = 12'd0;
    bus.csr_wdata_i   = 32'd0;
    bus.csr_raddr_i   = 12'd0;
    bus.mem_valid_i   = 1'b0;
    bus.mem_pc_i      = 32'd0;
    bus.exc_ecall_i   = 1'b0;
    bus.exc_ebreak_i  = 1'b0;
    bus.exc_illegal_i = 1'b0;
    bus.exc_ldmis_i   = 1'b0;
    bus.exc_stmis_i   = 1'b0;
    bus.exc_mret_i    = 1'b0;
    bus.timer_irq_i   = 1'b0;
    bus.ext_irq_i     = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we_i    = 1'b1;
    bus.csr_waddr_i = a;
    bus.csr_wdata_i = d;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
    bus.csr_raddr_i = a;
    exp_push(c_sel_rdata, exp, name);
  endtask

  // Monitor / comparator
  exp_t        m_e;
  logic [31:0] m_act;

  initial begin
    checks   = 0;
    failures = 0;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        m_e = sb_q.pop_front();
        case (m_e.sel)
          c_sel_rdata: m_act = bus.csr_rdata_o;
          c_sel_exc:   m_act = bus.excepttype_o;
          c_sel_mepc:  m_act = bus.mepc_o;
          default:     m_act = bus.mtvec_o;
        endcase
        checks = checks + 1;
        if (m_e.cyc != cyc) begin
          failures = failures + 1;
          $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", m_e.name, m_e.cyc, cyc);
        end else if (m_act !== m_e.exp) begin
          failures = failures + 1;
          $display("FAIL %s: got %h expected %h (cycle %0d)", m_e.name, m_act, m_e.exp, cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_in();
    step();
    step();

    // In reset: trap request and mepc write must not show through
    bus.mem_valid_i = 1'b1;
    bus.exc_ecall_i = 1'b1;
    csr_wr(12'h341, 32'h55);
    exp_push(c_sel_exc, 32'd0, "rst_exc");
    exp_push(c_sel_mepc, 32'd0, "rst_mepc");
    exp_push(c_sel_mtvec, MTVEC_RST, "rst_mtvec");
    rd(12'h305, MTVEC_RST, "rst_rd_mtvec");
    step();

    clear_in();
    rst = 1'b0;
    rd(12'hB00, 32'd0, "mcycle_after_rst");
    step();
    rd(12'hB00, 32'd1, "mcycle_incr");
    step();
    rd(12'h341, 32'd0, "mepc_after_rst");
    step();

    // Timer trap sequence
    csr_wr(12'h305, 32'h101);
    rd(12'h305, 32'h101, "mtvec_rd_fwd");
    exp_push(c_sel_mtvec, 32'h101, "mtvec_o_fwd");
    step();
    csr_wr(12'h304, 32'h80);
    rd(12'h305, 32'h101, "mtvec_reg");
    step();
    csr_wr(12'h300, 32'h8);
    rd(12'h304, 32'h80, "mie_reg");
    step();
    bus.csr_we_i    = 1'b0;
    bus.timer_irq_i = 1'b1;
    bus.mem_valid_i = 1'b1;
    bus.mem_pc_i    = 32'h204;
    exp_push(c_sel_exc, 32'd3, "timer_exc");
    rd(12'h344, 32'h80, "mip_timer");
    step();
    clear_in();
    rd(12'h341, 32'h204, "timer_mepc");
    exp_push(c_sel_exc, 32'd0, "idle_exc");
    exp_push(c_sel_mtvec, 32'h101, "mtvec_o_reg");
    step();
    rd(12'h342, 32'h8000_0007, "timer_mcause");
    step();
    rd(12'h300, 32'h80, "timer_mstatus");
    step();

    // mret
    bus.mem_valid_i = 1'b1;
    bus.exc_mret_i  = 1'b1;
    exp_push(c_sel_exc, 32'hFFFF_FFFF, "mret_exc");
    exp_push(c_sel_mepc, 32'h204, "mret_mepc_o");
    step();
    clear_in();
    rd(12'h300, 32'h88, "mret_mstatus");
    step();

    // Illegal beats ecall and a masked external interrupt
    csr_wr(12'h304, 32'h800);
    step();
    csr_wr(12'h300, 32'h0);
    step();
    bus.csr_we_i      = 1'b0;
    bus.mem_valid_i   = 1'b1;
    bus.exc_illegal_i = 1'b1;
    bus.exc_ecall_i   = 1'b1;
    bus.ext_irq_i     = 1'b1;
    bus.mem_pc_i      = 32'h123;
    exp_push(c_sel_exc, 32'd5, "illegal_exc");
    rd(12'h344, 32'h800, "mip_ext");
    step();
    clear_in();
    rd(12'h342, 32'd2, "illegal_mcause");
    step();
    rd(12'h341, 32'h120, "illegal_mepc_align");
    step();
    rd(12'h300, 32'h0, "illegal_mstatus");
    step();

    // Trap wins over a coincident mepc write
    csr_wr(12'h341, 32'h400);
    bus.mem_valid_i = 1'b1;
    bus.exc_ecall_i = 1'b1;
    bus.mem_pc_i    = 32'h300;
    exp_push(c_sel_exc, 32'd1, "ecall_exc");
    exp_push(c_sel_mepc, 32'h400, "mepc_o_fwd");
    step();
    clear_in();
    rd(12'h341, 32'h300, "ecall_mepc");
    step();
    rd(12'h342, 32'd11, "ecall_mcause");
    step();

    // Lower-priority synchronous exceptions
    bus.mem_valid_i  = 1'b1;
    bus.exc_ebreak_i = 1'b1;
    bus.exc_ldmis_i  = 1'b1;
    bus.exc_stmis_i  = 1'b1;
    exp_push(c_sel_exc, 32'd2, "ebreak_exc");
    step();
    bus.exc_ebreak_i = 1'b0;
    exp_push(c_sel_exc, 32'd6, "ldmis_exc");
    step();
    bus.exc_ldmis_i = 1'b0;
    exp_push(c_sel_exc, 32'd7, "stmis_exc");
    step();
    clear_in();
    bus.exc_ecall_i = 1'b1;
    exp_push(c_sel_exc, 32'd0, "no_valid_exc");
    rd(12'h342, 32'd6, "stmis_mcause");
    step();

    // External beats timer; then masked, then unmasked level
    clear_in();
    csr_wr(12'h304, 32'h880);
    step();
    csr_wr(12'h300, 32'h8);
    step();
    bus.csr_we_i    = 1'b0;
    bus.mem_valid_i = 1'b1;
    bus.ext_irq_i   = 1'b1;
    bus.timer_irq_i = 1'b1;
    exp_push(c_sel_exc, 32'd4, "ext_exc");
    step();
    bus.ext_irq_i = 1'b0;
    rd(12'h342, 32'h8000_000B, "ext_mcause");
    exp_push(c_sel_exc, 32'd0, "timer_masked");
    step();
    bus.mem_valid_i = 1'b0;
    csr_wr(12'h300, 32'h8);
    rd(12'h344, 32'h80, "mip_level");
    step();
    bus.csr_we_i    = 1'b0;
    bus.mem_valid_i = 1'b1;
    exp_push(c_sel_exc, 32'd3, "timer_unmasked");
    step();
    clear_in();

    // Unimplemented address and read-only mip
    csr_wr(12'h7C0, 32'hABCD);
    rd(12'h7C0, 32'hABCD, "unimpl_fwd");
    step();
    csr_wr(12'h344, 32'hFFFF_FFFF);
    rd(12'h7C0, 32'd0, "unimpl_read");
    step();
    bus.csr_we_i = 1'b0;
    rd(12'h344, 32'd0, "mip_ro");
    step();

    // mcycle carry
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    step();
    csr_wr(12'hB80, 32'd0);
    step();
    bus.csr_we_i = 1'b0;
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_loaded");
    step();
    rd(12'hB00, 32'd0, "mcycle_wrap");
    step();
    rd(12'hB80, 32'd1, "mcycleh_carry");
    step();

    // Asynchronous reset during a trap
    bus.mem_valid_i = 1'b1;
    bus.exc_ecall_i = 1'b1;
    bus.mem_pc_i    = 32'h888;
    bus.csr_raddr_i = 12'h305;
    #2;
    rst = 1'b1;
    exp_push(c_sel_exc, 32'd0, "async_rst_exc");
    exp_push(c_sel_mepc, 32'd0, "async_rst_mepc_o");
    exp_push(c_sel_rdata, MTVEC_RST, "async_rst_mtvec");
    step();
    clear_in();
    rd(12'h342, 32'd0, "async_rst_mcause");
    step();
    rst = 1'b0;
    rd(12'h341, 32'd0, "post_rst_mepc");
    step();
    csr_wr(12'h305, 32'h44);
    step();
    bus.csr_we_i = 1'b0;
    rd(12'h305, 32'h44, "post_rst_write");
    step();
    step();

    if (sb_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
